channel_frame_arbiter: RTL and testbench

Frame-level round-robin scheduler for the eight per-channel data FIFOs of the SFP transmit path. It watches per-channel frame-complete pulses, picks one channel at a time and drains exactly one whole frame from that channel's FIFO. It forwards each word as a registered write into the downstream serialized stream, honouring downstream back-pressure. It owns all channel FIFO read enables; no other block pops those FIFOs.

---
 rtl/channel_frame_arbiter_if.sv | 41 ++++
 rtl/channel_frame_arbiter.sv | 165 ++++++++++++++++
 tb/tb_channel_frame_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/channel_frame_arbiter_if.sv
// ============================================================================
// Module      : channel_frame_arbiter_if
// Description : Channel FIFO heads/pops plus serialized output bundle for the
//               frame-level round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface channel_frame_arbiter_if #(
    parameter int DATA_WIDTH  = 64,
    parameter int CHANNEL_NUM = 8
);
    localparam int SEL_WIDTH = $clog2(CHANNEL_NUM);

    logic [CHANNEL_NUM*(DATA_WIDTH+1)-1:0] FIFO_DOUTS;
    logic [CHANNEL_NUM-1:0]                FIFO_EMPTYS;
    logic [CHANNEL_NUM-1:0]                FIFO_RE_ENS;
    logic [CHANNEL_NUM-1:0]                FRAME_PUSH;
    logic [CHANNEL_NUM-1:0]                CH_ENABLE;
    logic                                  PLS_WAIT;
    logic [DATA_WIDTH-1:0]                 SERIALIZED_DATA;
    logic                                  SERIALIZED_LAST;
    logic                                  WR_EN;
    logic [SEL_WIDTH-1:0]                  SELECTED_CHANNEL;
    logic                                  BUSY;
    logic [CHANNEL_NUM-1:0]                CNT_OVERFLOW;

    modport master (
        output FIFO_DOUTS, FIFO_EMPTYS, FRAME_PUSH, CH_ENABLE, PLS_WAIT,
        input  FIFO_RE_ENS, SERIALIZED_DATA, SERIALIZED_LAST, WR_EN,
               SELECTED_CHANNEL, BUSY, CNT_OVERFLOW
    );

    modport slave (
        input  FIFO_DOUTS, FIFO_EMPTYS, FRAME_PUSH, CH_ENABLE, PLS_WAIT,
        output FIFO_RE_ENS, SERIALIZED_DATA, SERIALIZED_LAST, WR_EN,
               SELECTED_CHANNEL, BUSY, CNT_OVERFLOW
    );
endinterface

`default_nettype wire

// File: rtl/channel_frame_arbiter.sv
// ============================================================================
// Module      : channel_frame_arbiter
// Description : Round-robin frame scheduler draining one whole frame at a time
//               from eight FWFT channel FIFOs into a registered serial stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module channel_frame_arbiter #(
    parameter int DATA_WIDTH      = 64,
    parameter int CHANNEL_NUM     = 8,
    parameter int FRAME_CNT_WIDTH = 8
) (
    input  wire logic              TX_ACLK,
    input  wire logic              TX_ARESET,
    channel_frame_arbiter_if.slave bus
);
    localparam int SEL_W   = $clog2(CHANNEL_NUM);
    localparam int SLICE_W = DATA_WIDTH + 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [SEL_W-1:0]      r_sel;
    logic [SEL_W-1:0]      w_sel_nxt;
    logic [SEL_W-1:0]      r_rr;
    logic [SEL_W-1:0]      w_rr_nxt;
    logic [SEL_W-1:0]      w_grant;
    logic                  w_grant_valid;
    logic                  w_pop;
    logic [CHANNEL_NUM-1:0] w_cand;
    logic [CHANNEL_NUM-1:0] w_re;
    logic [SLICE_W-1:0]    w_slices [CHANNEL_NUM];
    logic [SLICE_W-1:0]    w_head;
    logic                  w_head_last;
    logic                  r_wr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_last;

    generate
        for (genvar j = 0; j < CHANNEL_NUM; j++) begin : g_slices
            assign w_slices[j] = bus.FIFO_DOUTS[j*SLICE_W +: SLICE_W];
        end
    endgenerate

    assign w_head      = w_slices[r_sel];
    assign w_head_last = w_head[DATA_WIDTH];

    // Per-channel count of fully written frames still waiting in the FIFO
    generate
        for (genvar j = 0; j < CHANNEL_NUM; j++) begin : g_pend
            logic [FRAME_CNT_WIDTH-1:0] r_cnt;
            logic                       r_ovf;
            logic                       w_inc;
            logic                       w_dec;

            assign w_inc = bus.FRAME_PUSH[j];
            assign w_dec = w_pop && (r_sel == SEL_W'(j)) && w_head_last;

            always_ff @(posedge TX_ACLK) begin
                if (TX_ARESET) begin
                    r_cnt <= '0;
                    r_ovf <= 1'b0;
                end else if (w_inc && !w_dec) begin
                    if (&r_cnt) begin
                        r_ovf <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + FRAME_CNT_WIDTH'(1);
                    end
                end else if (w_dec && !w_inc && (r_cnt != '0)) begin
                    r_cnt <= r_cnt - FRAME_CNT_WIDTH'(1);
                end
            end

            assign w_cand[j]            = bus.CH_ENABLE[j] && (r_cnt != '0);
            assign bus.CNT_OVERFLOW[j]  = r_ovf;
        end
    endgenerate

    // First candidate at or above the pointer wins; the highest offset is
    // visited first so the lowest matching offset is what remains.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant       = r_rr;
        for (int k = CHANNEL_NUM - 1; k >= 0; k--) begin
            if (w_cand[r_rr + SEL_W'(k)]) begin
                w_grant_valid = 1'b1;
                w_grant       = r_rr + SEL_W'(k);
            end
        end
    end

    always_ff @(posedge TX_ACLK) begin
        if (TX_ARESET) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
            r_rr    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_rr    <= w_rr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_rr_nxt    = r_rr;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_valid) begin
                    w_state_nxt = ST_XFER;
                    w_sel_nxt   = w_grant;
                end
            end
            ST_XFER: begin
                // Reset gates the pop in the very cycle it is sampled
                w_pop = !bus.FIFO_EMPTYS[r_sel] && !bus.PLS_WAIT && !TX_ARESET;
                if (w_pop && w_head_last) begin
                    w_state_nxt = ST_IDLE;
                    w_rr_nxt    = r_sel + SEL_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_re = '0;
        if (w_pop) begin
            w_re[r_sel] = 1'b1;
        end
    end

    always_ff @(posedge TX_ACLK) begin
        if (TX_ARESET) begin
            r_wr   <= 1'b0;
            r_data <= '0;
            r_last <= 1'b0;
        end else begin
            r_wr <= w_pop;
            if (w_pop) begin
                r_data <= w_head[DATA_WIDTH-1:0];
                r_last <= w_head_last;
            end
        end
    end

    assign bus.FIFO_RE_ENS      = w_re;
    assign bus.WR_EN            = r_wr;
    assign bus.SERIALIZED_DATA  = r_data;
    assign bus.SERIALIZED_LAST  = r_last;
    assign bus.SELECTED_CHANNEL = r_sel;
    assign bus.BUSY             = (r_state == ST_XFER);

endmodule

`default_nettype wire

// File: tb/tb_channel_frame_arbiter.sv
// ============================================================================
// Module      : tb_channel_frame_arbiter
// Description : Directed scenarios plus randomized traffic against a
//               frame-level reference model of channel_frame_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_channel_frame_arbiter;
    localparam int DW = 64;
    localparam int CN = 8;

    typedef struct {
        int          cyc;
        logic [63:0] data;
        logic        last;
        logic [2:0]  sel;
    } wr_t;

    logic clk;
    logic rst;

    channel_frame_arbiter_if #(.DATA_WIDTH(DW), .CHANNEL_NUM(CN)) bus ();

    channel_frame_arbiter #(
        .DATA_WIDTH      (DW),
        .CHANNEL_NUM     (CN),
        .FRAME_CNT_WIDTH (8)
    ) dut (
        .TX_ACLK   (clk),
        .TX_ARESET (rst),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [64:0] fq [CN][$];
    wr_t         log_q [$];
    int          wr_rem [CN];
    logic [7:0]  push_v;
    logic [7:0]  en_v;
    logic        wait_v;
    logic        rst_v;
    int          cyc;
    int          total;
    int          bad;

    // reference model state
    bit          m_busy;
    int          m_sel;
    int          m_rr;
    int          m_pend [CN];
    bit [7:0]    m_ovf;
    bit          m_wr;
    logic [63:0] m_data;
    bit          m_last;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_tick(input bit rst_i, input bit [7:0] push_i, input bit [7:0] en_i,
                              input bit pop_i, input logic [64:0] head_i);
        bit found;
        int g;
        bit inc;
        bit dec;
        if (rst_i) begin
            m_busy = 0; m_sel = 0; m_rr = 0; m_ovf = '0;
            m_wr = 0; m_data = '0; m_last = 0;
            for (int j = 0; j < CN; j++) m_pend[j] = 0;
            return;
        end
        found = 0;
        g     = 0;
        for (int k = 0; k < CN; k++) begin
            if (!found && en_i[(m_rr + k) % CN] && m_pend[(m_rr + k) % CN] > 0) begin
                found = 1;
                g     = (m_rr + k) % CN;
            end
        end
        for (int j = 0; j < CN; j++) begin
            inc = push_i[j];
            dec = pop_i && (m_sel == j) && head_i[64];
            if (inc && !dec) begin
                if (m_pend[j] == 255) m_ovf[j] = 1;
                else m_pend[j]++;
            end else if (dec && !inc && m_pend[j] > 0) begin
                m_pend[j]--;
            end
        end
        m_wr = pop_i;
        if (pop_i) begin
            m_data = head_i[63:0];
            m_last = head_i[64];
        end
        if (m_busy) begin
            if (pop_i && head_i[64]) begin
                m_busy = 0;
                m_rr   = (m_sel + 1) % CN;
            end
        end else if (found) begin
            m_busy = 1;
            m_sel  = g;
        end
    endtask

    task automatic step();
        logic [CN*65-1:0] d;
        logic [7:0]       e;
        logic [7:0]       re;
        logic [64:0]      head;
        bit               p;
        for (int j = 0; j < CN; j++) begin
            if (fq[j].size() > 0) begin
                d[j*65 +: 65] = fq[j][0];
                e[j] = 1'b0;
            end else begin
                d[j*65 +: 65] = {1'b1, 64'hDEAD_BEEF_0BAD_F00D};
                e[j] = 1'b1;
            end
        end
        bus.FIFO_DOUTS  = d;
        bus.FIFO_EMPTYS = e;
        bus.FRAME_PUSH  = push_v;
        bus.CH_ENABLE   = en_v;
        bus.PLS_WAIT    = wait_v;
        rst             = rst_v;
        #2;
        p    = !rst_v && m_busy && !e[m_sel] && !wait_v;
        head = p ? fq[m_sel][0] : 65'd0;
        re   = bus.FIFO_RE_ENS;
        check("re_ens", re, p ? (8'b1 << m_sel) : 8'b0);
        model_tick(rst_v, push_v, en_v, p, head);
        @(posedge clk);
        #1;
        cyc++;
        for (int j = 0; j < CN; j++) begin
            if (re[j] && fq[j].size() > 0) void'(fq[j].pop_front());
        end
        if (bus.WR_EN) log_q.push_back('{cyc, bus.SERIALIZED_DATA, bus.SERIALIZED_LAST, bus.SELECTED_CHANNEL});
        check("wr_en", bus.WR_EN, m_wr);
        check("ser_data", bus.SERIALIZED_DATA, m_data);
        check("ser_last", bus.SERIALIZED_LAST, m_last);
        check("busy", bus.BUSY, m_busy);
        check("sel", bus.SELECTED_CHANNEL, m_sel);
        check("cnt_ovf", bus.CNT_OVERFLOW, m_ovf);
        push_v = '0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic apply_reset();
        rst_v = 1'b1;
        for (int j = 0; j < CN; j++) begin
            fq[j].delete();
            wr_rem[j] = 0;
        end
        run(2);
        rst_v = 1'b0;
        log_q.delete();
    endtask

    task automatic load(input int ch, input int first, input int n);
        for (int i = 0; i < n; i++) fq[ch].push_back({(i == n - 1), 64'(first + i)});
    endtask

    task automatic check_log(input string tag, input int idx, input int exp_cyc,
                             input logic [63:0] exp_data, input logic exp_last);
        if (idx < log_q.size()) begin
            check({tag, "_cyc"}, log_q[idx].cyc, exp_cyc);
            check({tag, "_data"}, log_q[idx].data, exp_data);
            check({tag, "_last"}, log_q[idx].last, exp_last);
        end
    endtask

    initial begin
        int t;
        int c;
        bit done;
        total = 0; bad = 0; cyc = 0;
        push_v = '0; en_v = 8'hFF; wait_v = 1'b0; rst_v = 1'b1;
        model_tick(1'b1, '0, '0, 1'b0, '0);
        apply_reset();
        check("rst_busy", bus.BUSY, 0);
        check("rst_wr", bus.WR_EN, 0);

        // single frame on ch3
        load(3, 'h30, 4);
        t = cyc; push_v[3] = 1'b1;
        run(10);
        check("single_n", log_q.size(), 4);
        for (int i = 0; i < 4; i++) check_log("single", i, t + 3 + i, 'h30 + i, i == 3);

        // round robin from a fresh pointer, then a late ch0 push served after 7
        apply_reset();
        load(0, 'h00, 2); load(2, 'h20, 2); load(7, 'h70, 2);
        t = cyc; push_v = 8'b1000_0101;
        run(14);
        check("rr1_n", log_q.size(), 6);
        for (int i = 0; i < 6; i++)
            check_log("rr1", i, t + 3 + i + i / 2, (i / 2 == 0 ? 'h00 : i / 2 == 1 ? 'h20 : 'h70) + i % 2, i % 2);
        log_q.delete();
        load(0, 'h00, 2); load(2, 'h20, 2); load(7, 'h70, 2);
        t = cyc; push_v = 8'b1000_0100;
        step();
        push_v[0] = 1'b1;
        run(13);
        check("rr2_n", log_q.size(), 6);
        for (int i = 0; i < 6; i++)
            check_log("rr2", i, t + 3 + i + i / 2, (i / 2 == 0 ? 'h20 : i / 2 == 1 ? 'h70 : 'h00) + i % 2, i % 2);

        // back-pressure for three cycles after the second pop
        log_q.delete();
        load(1, 'h10, 8);
        t = cyc; push_v[1] = 1'b1;
        for (int i = 0; i < 18; i++) begin
            wait_v = (cyc >= t + 4) && (cyc <= t + 6);
            step();
        end
        wait_v = 1'b0;
        check("bp_n", log_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check_log("bp", i, t + 3 + i + (i >= 2 ? 3 : 0), 'h10 + i, i == 7);
            if (i < log_q.size()) check("bp_sel", log_q[i].sel, 1);
        end

        // FIFO runs dry mid-frame while the channel gets disabled
        log_q.delete();
        load(5, 'h50, 2);
        fq[5][1][64] = 1'b0;
        t = cyc; push_v[5] = 1'b1;
        run(4);
        en_v[5] = 1'b0;
        run(6);
        fq[5].push_back({1'b0, 64'h52}); fq[5].push_back({1'b0, 64'h53});
        fq[5].push_back({1'b1, 64'h54}); fq[5].push_back({1'b1, 64'h55});
        push_v[5] = 1'b1;
        run(14);
        check("dry_n", log_q.size(), 5);
        for (int i = 0; i < 2; i++) check_log("dry_a", i, t + 3 + i, 'h50 + i, 0);
        for (int i = 2; i < 5; i++) check_log("dry_b", i, t + 9 + i, 'h50 + i, i == 4);
        check("dry_left", fq[5].size(), 1);
        en_v = 8'hFF;

        // push and last-pop coincide on ch4
        apply_reset();
        load(4, 'h40, 3); load(4, 'h43, 2);
        push_v[4] = 1'b1;
        done = 0;
        for (int i = 0; i < 20; i++) begin
            if (!done && m_busy && m_sel == 4 && fq[4].size() == 3) begin
                push_v[4] = 1'b1;
                done = 1;
            end
            step();
        end
        check("coinc_n", log_q.size(), 5);
        check_log("coinc", 4, log_q.size() > 4 ? log_q[4].cyc : 0, 'h44, 1);

        // 256 pushes while disabled: counter saturates at 255 frames
        apply_reset();
        en_v[6] = 1'b0;
        for (int i = 0; i < 256; i++) fq[6].push_back({1'b1, 64'(i)});
        for (int i = 0; i < 256; i++) begin
            push_v[6] = 1'b1;
            step();
        end
        run(2);
        check("ovf6", bus.CNT_OVERFLOW[6], 1);
        en_v[6] = 1'b1;
        log_q.delete();
        run(560);
        check("sat_frames", log_q.size(), 255);
        check("sat_left", fq[6].size(), 1);

        // reset while the third word of a ch2 frame would pop
        apply_reset();
        load(2, 'h20, 5);
        push_v[2] = 1'b1;
        run(4);
        rst_v = 1'b1;
        step();
        rst_v = 1'b0;
        check("mrst_wr", bus.WR_EN, 0);
        check("mrst_data", bus.SERIALIZED_DATA, 0);
        check("mrst_sel", bus.SELECTED_CHANNEL, 0);
        log_q.delete();
        run(10);
        check("mrst_quiet", log_q.size(), 0);
        push_v[2] = 1'b1;
        run(10);
        check("mrst_resume_n", log_q.size(), 3);
        check_log("mrst_resume", 0, log_q.size() > 0 ? log_q[0].cyc : 0, 'h22, 0);

        // randomized traffic
        apply_reset();
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 49) == 0) en_v = 8'($urandom);
            wait_v = ($urandom_range(0, 4) == 0);
            for (int n = 0; n < 2; n++) begin
                c = $urandom_range(0, 7);
                if (fq[c].size() < 32 && !push_v[c] && $urandom_range(0, 1) == 1) begin
                    if (wr_rem[c] == 0) wr_rem[c] = $urandom_range(1, 5);
                    fq[c].push_back({(wr_rem[c] == 1), 32'($urandom), 32'($urandom)});
                    if (wr_rem[c] == 1) push_v[c] = 1'b1;
                    wr_rem[c]--;
                end
            end
            step();
        end
        en_v = 8'hFF;
        wait_v = 1'b0;
        run(400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
